keypad_scan: RTL and testbench

Scanner for a 4x4 matrix keypad: the input-side counterpart of the multiplexed 7-segment display driver. It drives one keypad column low at a time, advancing on the shared `refresh` tick, and samples the rows through a synchroniser. Each complete 4-column scan produces one frame result, which is debounced across frames. For every debounced key press it emits a 4-bit key code with a one-cycle valid pulse, feeding the parameter-entry logic of the monitoring system.

---
 rtl/keypad_scan.sv | 170 +++++++++++++++++
 tb/tb_keypad_scan.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame-level debounce.
// One column is driven low per refresh tick. The rows are sampled per column
// and merged into a frame result, which is debounced across frames.
module keypad_scan #(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refresh,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {K_NONE, K_MULTI, K_KEY} kind_t;
    typedef enum logic {IDLE, PRESSED} state_t;

    localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

    logic [3:0] row_m, row_s;
    logic [1:0] cidx;
    kind_t      col_kind;
    logic [1:0] col_r;
    kind_t      acc_kind, mrg_kind, cand_kind;
    logic [3:0] acc_code, mrg_code, cand_code;
    logic [3:0] cnt, cnt_nxt;
    logic       frame_done, same, stable;
    state_t     state, state_nxt;
    logic       load, held_nxt;

    // Two-flop synchroniser for the asynchronous rows (idle level is all ones)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_m <= '1;
            row_s <= '1;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    // Column counter advances on each refresh tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cidx <= '0;
        else if (refresh) cidx <= cidx + 2'd1;
    end

    // Active-low one-cold column drive
    always_comb begin
        col = ~(4'b0001 << cidx);
    end

    // Classify the sampled rows of the current column
    always_comb begin
        col_kind = K_MULTI;
        col_r    = '0;
        case (row_s)
            4'b1111: col_kind = K_NONE;
            4'b1110: begin col_kind = K_KEY; col_r = 2'd0; end
            4'b1101: begin col_kind = K_KEY; col_r = 2'd1; end
            4'b1011: begin col_kind = K_KEY; col_r = 2'd2; end
            4'b0111: begin col_kind = K_KEY; col_r = 2'd3; end
            default: col_kind = K_MULTI;
        endcase
    end

    // Merge the current column into the running frame result
    always_comb begin
        mrg_kind = acc_kind;
        mrg_code = acc_code;
        if (col_kind == K_MULTI) begin
            mrg_kind = K_MULTI;
        end else if (col_kind == K_KEY) begin
            if (acc_kind == K_NONE) begin
                mrg_kind = K_KEY;
                mrg_code = {col_r, cidx};
            end else begin
                mrg_kind = K_MULTI;
            end
        end
    end

    assign frame_done = refresh && (cidx == 2'd3);

    // Frame accumulator; clears when the frame closes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_kind <= K_NONE;
            acc_code <= '0;
        end else if (frame_done) begin
            acc_kind <= K_NONE;
            acc_code <= '0;
        end else if (refresh) begin
            acc_kind <= mrg_kind;
            acc_code <= mrg_code;
        end
    end

    // Next stable count for the frame that is closing
    always_comb begin
        same = (mrg_kind == cand_kind) && ((mrg_kind != K_KEY) || (mrg_code == cand_code));
        if (!same)          cnt_nxt = 4'd1;
        else if (cnt >= DB) cnt_nxt = DB;
        else                cnt_nxt = cnt + 4'd1;
        stable = frame_done && (cnt_nxt == DB);
    end

    // Debounce candidate and stable counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_kind <= K_NONE;
            cand_code <= '0;
            cnt       <= '0;
        end else if (frame_done) begin
            cand_kind <= mrg_kind;
            cand_code <= mrg_code;
            cnt       <= cnt_nxt;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM next state; decisions use the candidate as updated by this frame
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        held_nxt  = key_held;
        case (state)
            IDLE: begin
                if (stable && mrg_kind == K_KEY) begin
                    load      = 1'b1;
                    held_nxt  = 1'b1;
                    state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                if (stable && !(mrg_kind == K_KEY && mrg_code == key_code)) begin
                    if (mrg_kind == K_KEY) begin
                        load     = 1'b1;
                        held_nxt = 1'b1;
                    end else begin
                        held_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs; key_code persists across release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= load;
            key_held  <= held_nxt;
            if (load) key_code <= mrg_code;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed stimulus with a keypad model; expected key codes
// are queued by the stimulus and consumed by a monitor on each key_valid.
module tb_keypad_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       refresh = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = '0;   // bit 4*r+c set = key (r,c) pressed
    logic [3:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;

    keypad_scan #(.DEBOUNCE_SCANS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .refresh   (refresh),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad model: row r pulled low while a pressed key's column is driven low
    always_comb begin
        row = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    // Monitor: every key_valid pulse must match the next queued expectation
    always @(negedge clk) begin
        if (rst && key_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: key_code=%0d, required no pulse", key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (key_code !== e || key_held !== 1'b1) begin
                    errors++;
                    $display("FAIL pulse: key_code=%0d held=%0b, required key_code=%0d held=1",
                             key_code, key_held, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        repeat (7) @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    // n full frames; settle afterwards so the monitor has seen the last edge
    task automatic frames(input int n);
        repeat (n * 4) tick();
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_col"},   8'(col), 8'hE);
        check({tag, "_code"},  8'(key_code), 8'h0);
        check({tag, "_valid"}, 8'(key_valid), 8'h0);
        check({tag, "_held"},  8'(key_held), 8'h0);
    endtask

    initial begin
        logic [3:0] col_seq [4];
        col_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // Reset and column cycling
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            check($sformatf("col_step%0d", i), 8'(col), 8'(col_seq[i]));
        end

        // Stable press (2,1) -> code 9 after 4 frames, no repeats
        keys = 16'h0200;
        exp_q.push_back(4'd9);
        frames(3);
        check("press_early_pending", 8'(exp_q.size()), 8'd1);
        check("press_early_held", 8'(key_held), 8'h0);
        frames(1);
        check("press_pending", 8'(exp_q.size()), 8'd0);
        check("press_held", 8'(key_held), 8'h1);
        check("press_code", 8'(key_code), 8'h9);
        frames(10);
        check("press_hold_held", 8'(key_held), 8'h1);

        // Release: held drops on the 4th NONE frame, code stays
        keys = '0;
        frames(3);
        check("release_early_held", 8'(key_held), 8'h1);
        frames(1);
        check("release_held", 8'(key_held), 8'h0);
        check("release_code", 8'(key_code), 8'h9);

        // Re-press (0,0)
        keys = 16'h0001;
        exp_q.push_back(4'd0);
        frames(4);
        check("repress_pending", 8'(exp_q.size()), 8'd0);
        check("repress_code", 8'(key_code), 8'h0);
        check("repress_held", 8'(key_held), 8'h1);
        keys = '0;
        frames(4);
        check("repress_release_held", 8'(key_held), 8'h0);

        // Bounce on (1,3): alternate frames, never accepted
        for (int i = 0; i < 12; i++) begin
            keys = (i % 2 == 0) ? 16'h0080 : 16'h0000;
            frames(1);
        end
        check("bounce_held", 8'(key_held), 8'h0);
        check("bounce_code", 8'(key_code), 8'h0);

        // Two keys (0,0)+(3,3): MULTI never accepted; release (3,3) -> code 0
        keys = 16'h8001;
        frames(8);
        check("multi_held", 8'(key_held), 8'h0);
        keys = 16'h0001;
        exp_q.push_back(4'd0);
        frames(3);
        check("multi_rel_early_pending", 8'(exp_q.size()), 8'd1);
        frames(1);
        check("multi_rel_pending", 8'(exp_q.size()), 8'd0);
        check("multi_rel_held", 8'(key_held), 8'h1);

        // Reset after 3 stable frames of (2,1); needs 4 fresh frames
        keys = 16'h0200;
        frames(3);
        rst = 1'b0;
        #1;
        check_reset_values("midreset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(4'd9);
        frames(3);
        check("postreset_early_pending", 8'(exp_q.size()), 8'd1);
        check("postreset_early_held", 8'(key_held), 8'h0);
        frames(1);
        check("postreset_pending", 8'(exp_q.size()), 8'd0);
        check("postreset_code", 8'(key_code), 8'h9);
        check("postreset_held", 8'(key_held), 8'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
